// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debouncer.
// State encodings are visible to any block that imports this package.
package btn_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, stability FSM,
// press/release pulses and a wrapping press counter.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DB_CYCLES  = 16,
  parameter int CNT_W      = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_IN,
  input  logic             CNT_CLR,
  output logic             BTN_LEVEL,
  output logic             PRESS_PULSE,
  output logic             RELEASE_PULSE,
  output logic [CNT_W-1:0] PRESS_CNT
);

  localparam int DW = (DB_CYCLES > 1) ?
    $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX =
    DW'(DB_CYCLES - 1);

  logic       btn_pol;
  logic       s;
  btn_state_t state;
  logic [DW-1:0] dcnt;

  assign btn_pol = (ACTIVE_LOW != 0) ? ~BTN_IN : BTN_IN;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (btn_pol),
    .Q   (s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      dcnt          <= '0;
      BTN_LEVEL     <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      PRESS_CNT     <= '0;
    end else begin
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      if (CNT_CLR)
        PRESS_CNT <= '0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
          end else if (dcnt == DMAX) begin
            state       <= PRESSED;
            BTN_LEVEL   <= 1'b1;
            PRESS_PULSE <= 1'b1;
            // a clear in the same cycle still counts this press
            PRESS_CNT   <= CNT_CLR ? CNT_W'(1)
                                   : PRESS_CNT + 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
          end else if (dcnt == DMAX) begin
            state         <= IDLE;
            BTN_LEVEL     <= 1'b0;
            RELEASE_PULSE <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DB_CYCLES=16, CNT_W=8),
// with a second instance exercising ACTIVE_LOW=1.
module tb_btn_debounce;
  import btn_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_IN;
  logic       CNT_CLR;
  logic       level, press, rel;
  logic [7:0] cnt;
  logic       btn_n;
  logic       level_n, press_n, rel_n;
  logic [7:0] cnt_n;

  int errors = 0;
  int checks = 0;
  int press_seen = 0;
  int rel_seen = 0;
  int both_seen = 0;

  always #5 CLK = ~CLK;

  btn_debounce #(
    .DB_CYCLES(16), .CNT_W(8), .ACTIVE_LOW(0)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_IN(BTN_IN),
    .CNT_CLR(CNT_CLR), .BTN_LEVEL(level),
    .PRESS_PULSE(press), .RELEASE_PULSE(rel),
    .PRESS_CNT(cnt)
  );

  btn_debounce #(
    .DB_CYCLES(16), .CNT_W(8), .ACTIVE_LOW(1)
  ) dut_n (
    .CLK(CLK), .RST(RST), .BTN_IN(btn_n),
    .CNT_CLR(1'b0), .BTN_LEVEL(level_n),
    .PRESS_PULSE(press_n), .RELEASE_PULSE(rel_n),
    .PRESS_CNT(cnt_n)
  );

  always @(posedge CLK) begin
    if (press) press_seen <= press_seen + 1;
    if (rel) rel_seen <= rel_seen + 1;
    if ((press && rel) || (press_n && rel_n))
      both_seen <= both_seen + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_once();
    BTN_IN = 1'b1;
    repeat (20) tick();
    BTN_IN = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL rst_level got=%b exp=0", level);
    end
    checks++;
    if (press !== 1'b0 || rel !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses got=%b%b exp=00",
               press, rel);
    end
    checks++;
    if (cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_cnt got=%0d exp=0", cnt);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_state got=%0d exp=%0d",
               dut.state, ST_IDLE);
    end
    RST = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_glitch();
    int p0, r0;
    p0 = press_seen;
    r0 = rel_seen;
    BTN_IN = 1'b1;
    repeat (10) tick();
    BTN_IN = 1'b0;
    repeat (40) tick();
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level got=%b exp=0", level);
    end
    checks++;
    if (press_seen != p0 || rel_seen != r0) begin
      errors++;
      $display("FAIL glitch_pulses got=%0d/%0d exp=0/0",
               press_seen - p0, rel_seen - r0);
    end
    checks++;
    if (cnt !== 8'd0) begin
      errors++;
      $display("FAIL glitch_cnt got=%0d exp=0", cnt);
    end
  endtask

  task automatic test_clean_press();
    BTN_IN = 1'b1;
    repeat (18) tick();
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL clean_early got=%b exp=0", level);
    end
    tick();
    checks++;
    if (level !== 1'b1 || press !== 1'b1) begin
      errors++;
      $display("FAIL clean_accept got=%b%b exp=11",
               level, press);
    end
    checks++;
    if (cnt !== 8'd1) begin
      errors++;
      $display("FAIL clean_cnt got=%0d exp=1", cnt);
    end
    checks++;
    if (dut.state !== ST_PRESSED) begin
      errors++;
      $display("FAIL clean_state got=%0d exp=%0d",
               dut.state, ST_PRESSED);
    end
    tick();
    checks++;
    if (press !== 1'b0 || level !== 1'b1) begin
      errors++;
      $display("FAIL clean_pulse1 got=%b%b exp=01",
               press, level);
    end
    repeat (20) tick();
    BTN_IN = 1'b0;
    repeat (18) tick();
    checks++;
    if (level !== 1'b1 || rel !== 1'b0) begin
      errors++;
      $display("FAIL rel_early got=%b%b exp=10",
               level, rel);
    end
    tick();
    checks++;
    if (level !== 1'b0 || rel !== 1'b1) begin
      errors++;
      $display("FAIL rel_accept got=%b%b exp=01",
               level, rel);
    end
    tick();
    checks++;
    if (rel !== 1'b0 || dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL rel_after got=%b/%0d exp=0/%0d",
               rel, dut.state, ST_IDLE);
    end
  endtask

  task automatic test_boundary();
    int p0;
    p0 = press_seen;
    BTN_IN = 1'b1;
    repeat (16) tick();
    BTN_IN = 1'b0;
    repeat (40) tick();
    checks++;
    if (press_seen != p0 || level !== 1'b0) begin
      errors++;
      $display("FAIL bound16 got=%0d/%b exp=0/0",
               press_seen - p0, level);
    end
    BTN_IN = 1'b1;
    repeat (17) tick();
    BTN_IN = 1'b0;
    tick();
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL bound17_early got=%b exp=0", level);
    end
    tick();
    checks++;
    if (press !== 1'b1 || cnt !== 8'd2) begin
      errors++;
      $display("FAIL bound17 got=%b/%0d exp=1/2",
               press, cnt);
    end
    repeat (40) tick();
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL bound17_rel got=%b exp=0", level);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = press_seen;
    for (int i = 0; i < 10; i++) begin
      BTN_IN = ~BTN_IN;
      repeat (3) tick();
    end
    BTN_IN = 1'b1;
    repeat (18) tick();
    checks++;
    if (level !== 1'b0 || press_seen != p0) begin
      errors++;
      $display("FAIL bounce_early got=%b/%0d exp=0/0",
               level, press_seen - p0);
    end
    tick();
    checks++;
    if (press !== 1'b1 || level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_accept got=%b%b exp=11",
               press, level);
    end
    repeat (5) tick();
    checks++;
    if (press_seen != p0 + 1 || cnt !== 8'd3) begin
      errors++;
      $display("FAIL bounce_once got=%0d/%0d exp=1/3",
               press_seen - p0, cnt);
    end
    BTN_IN = 1'b0;
    repeat (40) tick();
  endtask

  task automatic test_wrap_clear();
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    checks++;
    if (cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr got=%0d exp=0", cnt);
    end
    repeat (255) press_once();
    checks++;
    if (cnt !== 8'd255) begin
      errors++;
      $display("FAIL cnt255 got=%0d exp=255", cnt);
    end
    press_once();
    checks++;
    if (cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap got=%0d exp=0", cnt);
    end
    BTN_IN = 1'b1;
    repeat (18) tick();
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    checks++;
    if (press !== 1'b1 || cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_press got=%b/%0d exp=1/1",
               press, cnt);
    end
    tick();
    checks++;
    if (cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_hold got=%0d exp=1", cnt);
    end
    BTN_IN = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_reset_mid();
    int r0;
    BTN_IN = 1'b1;
    repeat (25) tick();
    checks++;
    if (dut.state !== ST_PRESSED || level !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got=%0d/%b exp=%0d/1",
               dut.state, level, ST_PRESSED);
    end
    r0 = rel_seen;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (level !== 1'b0 || rel !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%b%b exp=00",
               level, rel);
    end
    checks++;
    if (dut.state !== ST_IDLE || cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst_st got=%0d/%0d exp=%0d/0",
               dut.state, cnt, ST_IDLE);
    end
    repeat (18) tick();
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL mid_early got=%b exp=0", level);
    end
    tick();
    checks++;
    if (press !== 1'b1 || level !== 1'b1) begin
      errors++;
      $display("FAIL mid_repress got=%b%b exp=11",
               press, level);
    end
    BTN_IN = 1'b0;
    repeat (25) tick();
    checks++;
    if (rel_seen != r0 + 1) begin
      errors++;
      $display("FAIL mid_rel got=%0d exp=1",
               rel_seen - r0);
    end
  endtask

  task automatic test_active_low();
    btn_n = 1'b0;
    repeat (18) tick();
    checks++;
    if (level_n !== 1'b0) begin
      errors++;
      $display("FAIL al_early got=%b exp=0", level_n);
    end
    tick();
    checks++;
    if (press_n !== 1'b1 || level_n !== 1'b1 ||
        cnt_n !== 8'd1) begin
      errors++;
      $display("FAIL al_press got=%b%b/%0d exp=11/1",
               press_n, level_n, cnt_n);
    end
    repeat (20) tick();
    btn_n = 1'b1;
    repeat (18) tick();
    checks++;
    if (rel_n !== 1'b0 || level_n !== 1'b1) begin
      errors++;
      $display("FAIL al_rel_early got=%b%b exp=01",
               rel_n, level_n);
    end
    tick();
    checks++;
    if (rel_n !== 1'b1 || level_n !== 1'b0) begin
      errors++;
      $display("FAIL al_rel got=%b%b exp=10",
               rel_n, level_n);
    end
    repeat (3) tick();
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_seen != 0) begin
      errors++;
      $display("FAIL excl got=%0d exp=0", both_seen);
    end
  endtask

  initial begin
    RST = 1'b1;
    BTN_IN = 1'b0;
    btn_n = 1'b1;
    CNT_CLR = 1'b0;
    test_reset();
    test_glitch();
    test_clean_press();
    test_boundary();
    test_bounce();
    test_wrap_clear();
    test_reset_mid();
    test_active_low();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, consecutive stable synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 8, width of PRESS_CNT.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; when 1, BTN_IN is inverted before synchronization.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port BTN_IN  input  1  raw asynchronous push-button level.
REQ-007 SHALL have port CNT_CLR  input  1  synchronous clear of PRESS_CNT.
REQ-008 SHALL have port BTN_LEVEL  output  1  debounced, registered button level (1 = pressed).
REQ-009 SHALL have port PRESS_PULSE  output  1  one-cycle pulse on accepted press.
REQ-010 SHALL have port RELEASE_PULSE  output  1  one-cycle pulse on accepted release.
REQ-011 SHALL have port PRESS_CNT  output  CNT_W  count of accepted presses.

Function
REQ-012 SHALL pass the polarity-corrected BTN_IN through a 2-flop synchronizer; its output is s.
REQ-013 SHALL implement the FSM states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a stability counter dcnt of width clog2(DB_CYCLES).
REQ-014 IDLE: s=1 -> PRESS_WAIT with dcnt=0; otherwise stay in IDLE.
REQ-015 PRESS_WAIT: s=0 -> IDLE with no output change; s=1 and dcnt=DB_CYCLES-1 -> PRESSED; otherwise dcnt+1.
REQ-016 PRESSED: s=0 -> RELEASE_WAIT with dcnt=0; otherwise stay in PRESSED.
REQ-017 RELEASE_WAIT: s=1 -> PRESSED with no output change; s=0 and dcnt=DB_CYCLES-1 -> IDLE; otherwise dcnt+1.
REQ-018 BTN_LEVEL SHALL be registered and equal 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-019 On the PRESS_WAIT->PRESSED transition, PRESS_PULSE SHALL be 1 for exactly one cycle, in the same cycle BTN_LEVEL first reads 1.
REQ-020 On the RELEASE_WAIT->IDLE transition, RELEASE_PULSE SHALL be 1 for exactly one cycle, in the same cycle BTN_LEVEL first reads 0.
REQ-021 Latency: if BTN_IN is first sampled active at rising edge 1 and stays active, BTN_LEVEL and PRESS_PULSE SHALL be 1 after edge DB_CYCLES+3; release latency SHALL be the same.
REQ-022 An active input shorter than DB_CYCLES+1 consecutive synchronized samples SHALL produce no output change.
REQ-023 PRESS_CNT SHALL increment by 1 with each PRESS_PULSE, wrapping from 2^CNT_W-1 to 0.
REQ-024 CNT_CLR SHALL zero PRESS_CNT on the next edge. If CNT_CLR and a press acceptance fall in the same cycle, PRESS_CNT SHALL become 1.
REQ-025 PRESS_PULSE and RELEASE_PULSE SHALL never both be 1 in the same cycle.

Reset
REQ-026 While RST=1 at a rising edge: synchronizer flops SHALL load the inactive (post-polarity 0) level, state SHALL be IDLE, and dcnt SHALL be 0.
REQ-027 While RST=1 at a rising edge: BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE and PRESS_CNT SHALL all be 0.
REQ-028 Reset asserted in PRESSED or RELEASE_WAIT SHALL drop BTN_LEVEL to 0 on that edge without a RELEASE_PULSE.
REQ-029 After reset deasserts with BTN_IN held active, the press SHALL be accepted with the full REQ-021 latency, counted from the first edge with RST=0.
REQ-030 RST SHALL take priority over CNT_CLR and all FSM activity.

Structure
REQ-031 State encodings (2-bit) SHALL be defined as constants in the shared package btn_pkg, reused by the bench for state checking.
REQ-032 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value 0), instantiated once.
REQ-033 No other sub-modules SHALL be used.

Verification (DB_CYCLES=16, CNT_W=8)
REQ-034 Clean press: BTN_IN 0->1 held 40 cycles -> BTN_LEVEL=1 and PRESS_PULSE=1 after edge 19; PRESS_CNT=1.
REQ-035 Bounce: ten 0/1 toggles every 3 cycles, then held high -> exactly one PRESS_PULSE, 19 edges after the last rising toggle.
REQ-036 Glitch: BTN_IN high for 10 cycles, then low -> BTN_LEVEL stays 0, no pulses, PRESS_CNT=0.
REQ-037 Wrap and clear: 256 clean presses -> PRESS_CNT=0; CNT_CLR coincident with the 257th PRESS_PULSE -> PRESS_CNT=1.
REQ-038 Reset mid-press: RST=1 for 1 cycle while PRESSED -> BTN_LEVEL=0 next cycle, no RELEASE_PULSE; BTN_IN still high -> re-press accepted 19 edges after RST deasserts.
REQ-039 ACTIVE_LOW=1: BTN_IN 1->0 held -> PRESS_PULSE after edge 19; return to 1 -> RELEASE_PULSE after edge 19.
